random_word_collector: RTL and testbench
========================================

Name: random_word_collector

Overview:
- Downstream consumer of the single-bit debiasing stage.
- Gathers qualified random bits into WIDTH-bit words MSB-first and presents them on a valid/ready output port.
- Runs a repetition-count health test on the incoming bit stream and flags a stuck source.
- Counts words lost to back-pressure.

Parameters:
- WIDTH, 8: output word width in bits; legal range 2..32.
- EDGE_MODE, 1: bit qualification mode.
  - 0: bit_in is accepted in every cycle with bit_valid=1.
  - 1: bit_in is accepted in the cycle where bit_valid falls, i.e. previous-cycle bit_valid=1 and current bit_valid=0.
- REP_LIMIT, 16: number of consecutive identical accepted bits that trips the stuck detector; legal range 2..255.
- DROP_W, 8: width of the saturating drop counter.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- rst, input, 1: synchronous, active-high reset.
- bit_valid, input, 1: qualifier/toggle from the debias stage.
- bit_in, input, 1: debiased random bit.
- word, output, WIDTH: collected word; stable while word_valid=1 and word_ready=0.
- word_valid, output, 1: word holds an undelivered word.
- word_ready, input, 1: consumer accepts word when word_valid=1 and word_ready=1 at posedge.
- overrun, output, 1: sticky; set when a completed word is dropped.
- drop_count, output, DROP_W: number of dropped words; saturates at all-ones.
- stuck, output, 1: sticky; set when the repetition limit is reached.

Behaviour:
- Reset (rst=1 at posedge) clears:
  - outputs: word=0, word_valid=0, overrun=0, drop_count=0, stuck=0;
  - internal state: shift register=0, bit counter=0, run counter=0, last_bit=0, prev_valid=0.
- rst overrides everything, including a handshake in the same cycle. The word is lost and no delivery occurs.
- In EDGE_MODE=1, prev_valid is clocked every cycle. The first cycle after reset cannot produce an accept because prev_valid=0.
- Accept event: bit_in is shifted into the LSB, earlier bits move toward the MSB, and the bit counter increments. The first accepted bit of a word ends up in word[WIDTH-1].
- Word completion: an accept with bit counter = WIDTH-1 completes a word.
  - The counter wraps to 0.
  - Latency: word and word_valid update at the posedge that samples the final bit, so they are visible the cycle after that bit was presented.
- Output register, evaluated at the completing posedge:
  - If word_valid=0, or word_valid=1 with word_ready=1: load the new word; word_valid=1.
  - Otherwise: the new word is discarded, the held word is kept unchanged, overrun <= 1, and drop_count increments unless saturated.
- Handshake without completion: word_valid=1 and word_ready=1 clears word_valid. The word value is retained but not meaningful.
- word_ready while word_valid=0 has no effect.
- Health test, on each accept:
  - First accept after reset: run=1.
  - Otherwise, if bit_in==last_bit then run+1, else run=1.
  - last_bit <= bit_in.
  - If the new run value equals REP_LIMIT: stuck <= 1, the partial word is discarded (counter=0), and this accept does not complete a word even if the counter was WIDTH-1.
- While stuck=1:
  - Accepts are ignored; the shift register, counter and run are frozen.
  - A word already in the output register is still delivered normally.
  - Only rst clears stuck.
- drop_count saturation: at all-ones it holds, and overrun remains 1.

Test Plan:
- EDGE_MODE=1, WIDTH=8: drive bit_valid toggling 1/0 each cycle with bit_in = 1,0,1,1,0,0,1,0 valid at each falling edge; word_ready=1 -> word=0xB2, word_valid high for exactly one cycle, starting the cycle after the 8th falling-edge sample.
- EDGE_MODE=0, word_ready=0: feed 24 alternating bits (1,0,...) -> first word 0xAA is held; second and third completions are dropped; drop_count=2, overrun=1, word stays 0xAA.
- Simultaneous event: word_valid=1 holding 0xAA, word_ready=1 in the same cycle as completion of 0x55 -> no drop; word=0x55 and word_valid stays 1 in the next cycle.
- Stuck: REP_LIMIT=16, feed 16 consecutive 1s with no handshake -> stuck=1 after the 16th accept; one word 0xFF delivered from the first 8 bits; bits 9-16 discarded; further bit input produces no word.
- Reset mid-word: 5 bits accepted, then rst for 1 cycle -> all outputs 0; the next 8 accepted bits form a complete word with no residue from the first 5.
- Saturation: DROP_W=2, force 5 drops -> drop_count=3 held, overrun=1.

Source files
------------

// File: rtl/random_word_collector.sv
// Random word collector: packs qualified random bits MSB-first into WIDTH-bit
// words, hands them out over valid/ready, counts words lost to back-pressure
// and runs a repetition-count health test that latches a stuck flag.
module random_word_collector #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EDGE_MODE = 1,
  parameter int unsigned REP_LIMIT = 16,
  parameter int unsigned DROP_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic [WIDTH-1:0]  word,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overrun,
  output logic [DROP_W-1:0] drop_count,
  output logic              stuck
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RunW = 8;
  localparam logic [CntW-1:0] LastCnt  = CntW'(WIDTH - 1);
  localparam logic [RunW-1:0] RepLimit = RunW'(REP_LIMIT);
  localparam bit EdgeQual = (EDGE_MODE != 0);

  // The shift register only needs WIDTH-1 bits: the final bit arrives directly from bit_in.
  logic [WIDTH-2:0]  shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RunW-1:0]   run_q, run_d;
  logic              last_bit_q, last_bit_d;
  logic              prev_valid_q;
  logic [WIDTH-1:0]  word_q, word_d;
  logic              word_valid_q, word_valid_d;
  logic              overrun_q, overrun_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              stuck_q, stuck_d;

  logic              accept;
  logic              trip;
  logic              complete;
  logic [RunW-1:0]   run_next;
  logic [WIDTH-1:0]  new_word;

  // Qualify incoming bits, run the health test and build the next state.
  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    run_d        = run_q;
    last_bit_d   = last_bit_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    overrun_d    = overrun_q;
    drop_d       = drop_q;
    stuck_d      = stuck_q;

    if (EdgeQual) begin
      accept = ~stuck_q & prev_valid_q & ~bit_valid;
    end else begin
      accept = ~stuck_q & bit_valid;
    end

    // run_q == 0 only before the first accept after reset.
    if ((run_q == '0) || (bit_in != last_bit_q)) begin
      run_next = RunW'(1);
    end else begin
      run_next = run_q + RunW'(1);
    end

    trip     = accept && (run_next == RepLimit);
    complete = accept && !trip && (cnt_q == LastCnt);
    new_word = {shift_q, bit_in};

    if (accept) begin
      run_d      = run_next;
      last_bit_d = bit_in;
      if (trip) begin
        // Tripping the health test discards the partial word.
        stuck_d = 1'b1;
        cnt_d   = '0;
        shift_d = '0;
      end else begin
        shift_d = new_word[WIDTH-2:0];
        cnt_d   = complete ? '0 : cnt_q + CntW'(1);
      end
    end

    if (complete) begin
      if (!word_valid_q || word_ready) begin
        word_d       = new_word;
        word_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
        if (drop_q != '1) begin
          drop_d = drop_q + DROP_W'(1);
        end
      end
    end else if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      run_q        <= '0;
      last_bit_q   <= 1'b0;
      prev_valid_q <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      drop_q       <= '0;
      stuck_q      <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      run_q        <= run_d;
      last_bit_q   <= last_bit_d;
      prev_valid_q <= bit_valid;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
      drop_q       <= drop_d;
      stuck_q      <= stuck_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign overrun    = overrun_q;
  assign drop_count = drop_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_random_word_collector.sv
// Directed bench for random_word_collector: one edge-qualified instance and one
// level-qualified instance with a 2-bit drop counter.
module tb_random_word_collector;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Edge-mode instance (defaults).
  logic       bit_valid_e = 1'b0;
  logic       bit_in_e    = 1'b0;
  logic       word_ready_e = 1'b0;
  logic [7:0] word_e;
  logic       word_valid_e;
  logic       overrun_e;
  logic [7:0] drop_count_e;
  logic       stuck_e;

  // Level-mode instance, DROP_W=2.
  logic       bit_valid_l = 1'b0;
  logic       bit_in_l    = 1'b0;
  logic       word_ready_l = 1'b0;
  logic [7:0] word_l;
  logic       word_valid_l;
  logic       overrun_l;
  logic [1:0] drop_count_l;
  logic       stuck_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  random_word_collector #(
    .WIDTH(8), .EDGE_MODE(1), .REP_LIMIT(16), .DROP_W(8)
  ) dut_e (
    .clk(clk), .rst(rst), .bit_valid(bit_valid_e), .bit_in(bit_in_e),
    .word(word_e), .word_valid(word_valid_e), .word_ready(word_ready_e),
    .overrun(overrun_e), .drop_count(drop_count_e), .stuck(stuck_e)
  );

  random_word_collector #(
    .WIDTH(8), .EDGE_MODE(0), .REP_LIMIT(16), .DROP_W(2)
  ) dut_l (
    .clk(clk), .rst(rst), .bit_valid(bit_valid_l), .bit_in(bit_in_l),
    .word(word_l), .word_valid(word_valid_l), .word_ready(word_ready_l),
    .overrun(overrun_l), .drop_count(drop_count_l), .stuck(stuck_l)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bit_valid_e = 1'b0; word_ready_e = 1'b0;
    bit_valid_l = 1'b0; word_ready_l = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Edge mode: one high cycle, then the falling cycle carrying the bit.
  task automatic send_e(input logic b);
    @(negedge clk);
    bit_valid_e = 1'b1;
    @(negedge clk);
    bit_valid_e = 1'b0;
    bit_in_e    = b;
  endtask

  task automatic send_l(input logic b);
    @(negedge clk);
    bit_valid_l = 1'b1;
    bit_in_l    = b;
  endtask

  task automatic idle_l();
    @(negedge clk);
    bit_valid_l = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (word_e !== 8'h00 || word_valid_e !== 1'b0 || overrun_e !== 1'b0 ||
        drop_count_e !== 8'd0 || stuck_e !== 1'b0) begin
      errors++;
      $display("FAIL reset_edge: word=%h v=%b ovr=%b drop=%0d stuck=%b, expected all 0",
               word_e, word_valid_e, overrun_e, drop_count_e, stuck_e);
    end
    checks++;
    if (word_l !== 8'h00 || word_valid_l !== 1'b0 || overrun_l !== 1'b0 ||
        drop_count_l !== 2'd0 || stuck_l !== 1'b0) begin
      errors++;
      $display("FAIL reset_level: word=%h v=%b ovr=%b drop=%0d stuck=%b, expected all 0",
               word_l, word_valid_l, overrun_l, drop_count_l, stuck_l);
    end
  endtask

  task automatic test_edge_word();
    logic [7:0] bits;
    bits = 8'hB2;
    word_ready_e = 1'b1;
    for (int i = 7; i >= 1; i--) send_e(bits[i]);
    @(negedge clk);
    checks++;
    if (word_valid_e !== 1'b0) begin
      errors++;
      $display("FAIL edge_early_valid: word_valid=%b, expected 0", word_valid_e);
    end
    bit_valid_e = 1'b1;
    @(negedge clk);
    bit_valid_e = 1'b0;
    bit_in_e    = bits[0];
    @(negedge clk);
    checks++;
    if (word_valid_e !== 1'b1 || word_e !== 8'hB2) begin
      errors++;
      $display("FAIL edge_word: word=%h v=%b, expected b2 v=1", word_e, word_valid_e);
    end
    @(negedge clk);
    checks++;
    if (word_valid_e !== 1'b0) begin
      errors++;
      $display("FAIL edge_one_cycle: word_valid=%b, expected 0", word_valid_e);
    end
    word_ready_e = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] bits;
    bits = 8'h53;
    for (int i = 0; i < 5; i++) send_e(1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (word_e !== 8'h00 || word_valid_e !== 1'b0 || stuck_e !== 1'b0) begin
      errors++;
      $display("FAIL midword_reset: word=%h v=%b stuck=%b, expected 0 0 0",
               word_e, word_valid_e, stuck_e);
    end
    for (int i = 7; i >= 0; i--) send_e(bits[i]);
    @(negedge clk);
    checks++;
    if (word_valid_e !== 1'b1 || word_e !== 8'h53) begin
      errors++;
      $display("FAIL midword_fresh: word=%h v=%b, expected 53 v=1", word_e, word_valid_e);
    end
    // Reset beats a handshake in the same cycle.
    word_ready_e = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    word_ready_e = 1'b0;
    checks++;
    if (word_e !== 8'h00 || word_valid_e !== 1'b0) begin
      errors++;
      $display("FAIL reset_vs_handshake: word=%h v=%b, expected 00 v=0", word_e, word_valid_e);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    word_ready_l = 1'b0;
    for (int i = 0; i < 8; i++) send_l(~i[0]);
    idle_l();
    checks++;
    if (word_valid_l !== 1'b1 || word_l !== 8'hAA || overrun_l !== 1'b0) begin
      errors++;
      $display("FAIL first_word: word=%h v=%b ovr=%b, expected aa 1 0",
               word_l, word_valid_l, overrun_l);
    end
    for (int i = 8; i < 24; i++) send_l(~i[0]);
    idle_l();
    checks++;
    if (drop_count_l !== 2'd2 || overrun_l !== 1'b1 || word_l !== 8'hAA ||
        word_valid_l !== 1'b1) begin
      errors++;
      $display("FAIL drops: drop=%0d ovr=%b word=%h v=%b, expected 2 1 aa 1",
               drop_count_l, overrun_l, word_l, word_valid_l);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    bits = 8'h55;
    for (int i = 7; i >= 1; i--) send_l(bits[i]);
    @(negedge clk);
    bit_valid_l  = 1'b1;
    bit_in_l     = bits[0];
    word_ready_l = 1'b1;
    @(negedge clk);
    bit_valid_l  = 1'b0;
    word_ready_l = 1'b0;
    checks++;
    if (word_l !== 8'h55 || word_valid_l !== 1'b1 || drop_count_l !== 2'd2) begin
      errors++;
      $display("FAIL simultaneous: word=%h v=%b drop=%0d, expected 55 1 2",
               word_l, word_valid_l, drop_count_l);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) send_l(i[0]);
    idle_l();
    checks++;
    if (drop_count_l !== 2'd3) begin
      errors++;
      $display("FAIL sat_reach: drop=%0d, expected 3", drop_count_l);
    end
    for (int i = 16; i < 24; i++) send_l(i[0]);
    idle_l();
    checks++;
    if (drop_count_l !== 2'd3 || overrun_l !== 1'b1 || word_l !== 8'h55) begin
      errors++;
      $display("FAIL sat_hold: drop=%0d ovr=%b word=%h, expected 3 1 55",
               drop_count_l, overrun_l, word_l);
    end
    @(negedge clk);
    word_ready_l = 1'b1;
    @(negedge clk);
    word_ready_l = 1'b0;
    checks++;
    if (word_valid_l !== 1'b0 || overrun_l !== 1'b1) begin
      errors++;
      $display("FAIL handshake_clear: v=%b ovr=%b, expected 0 1", word_valid_l, overrun_l);
    end
  endtask

  task automatic test_stuck();
    do_reset();
    for (int i = 0; i < 8; i++) send_l(1'b1);
    idle_l();
    checks++;
    if (word_valid_l !== 1'b1 || word_l !== 8'hFF || stuck_l !== 1'b0) begin
      errors++;
      $display("FAIL stuck_first_word: word=%h v=%b stuck=%b, expected ff 1 0",
               word_l, word_valid_l, stuck_l);
    end
    for (int i = 8; i < 15; i++) send_l(1'b1);
    idle_l();
    checks++;
    if (stuck_l !== 1'b0) begin
      errors++;
      $display("FAIL stuck_early: stuck=%b after 15 ones, expected 0", stuck_l);
    end
    send_l(1'b1);
    idle_l();
    checks++;
    if (stuck_l !== 1'b1 || drop_count_l !== 2'd0 || overrun_l !== 1'b0) begin
      errors++;
      $display("FAIL stuck_trip: stuck=%b drop=%0d ovr=%b, expected 1 0 0",
               stuck_l, drop_count_l, overrun_l);
    end
    for (int i = 0; i < 8; i++) send_l(1'b0);
    idle_l();
    checks++;
    if (drop_count_l !== 2'd0 || word_l !== 8'hFF || word_valid_l !== 1'b1) begin
      errors++;
      $display("FAIL stuck_frozen: drop=%0d word=%h v=%b, expected 0 ff 1",
               drop_count_l, word_l, word_valid_l);
    end
    @(negedge clk);
    word_ready_l = 1'b1;
    @(negedge clk);
    word_ready_l = 1'b0;
    checks++;
    if (word_valid_l !== 1'b0 || stuck_l !== 1'b1) begin
      errors++;
      $display("FAIL stuck_deliver: v=%b stuck=%b, expected 0 1", word_valid_l, stuck_l);
    end
    for (int i = 0; i < 8; i++) send_l(i[0]);
    idle_l();
    checks++;
    if (word_valid_l !== 1'b0 || stuck_l !== 1'b1) begin
      errors++;
      $display("FAIL stuck_no_word: v=%b stuck=%b, expected 0 1", word_valid_l, stuck_l);
    end
    do_reset();
    checks++;
    if (stuck_l !== 1'b0) begin
      errors++;
      $display("FAIL stuck_reset: stuck=%b, expected 0", stuck_l);
    end
  endtask

  initial begin
    test_reset();
    test_edge_word();
    test_reset_mid_word();
    test_overrun();
    test_back_to_back();
    test_saturation();
    test_stuck();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
